// File: rtl/trace_pack_pkg.sv
// Shared types and helpers for the trace line packer.
// Holds the FSM state enum, count-width helper and entry type.
package trace_pack_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pack_state_e;

  localparam int TP_DATA_SIZE = 10;

  typedef logic [TP_DATA_SIZE-1:0] entry_t;

  // Bits needed to hold a count in 0..n
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/generic_rotate.sv
// Slot-granular rotate/shift of a packed vector of entries.
// IS_SHIFT zero-fills the vacated slots instead of wrapping.
module generic_rotate #(
  parameter int NUM_OUT   = 16,
  parameter int DATA_SIZE = 10,
  parameter int ROT_LEFT  = 1,
  parameter int IS_SHIFT  = 1,
  parameter int AMT_W     = $clog2(NUM_OUT)
) (
  input  logic [NUM_OUT*DATA_SIZE-1:0] in_data,
  input  logic [AMT_W-1:0]             amt,
  output logic [NUM_OUT*DATA_SIZE-1:0] out_data
);

  // Move every slot by amt positions
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (ROT_LEFT != 0) begin
        if (i >= int'(amt))
          out_data[i*DATA_SIZE +: DATA_SIZE] =
            in_data[(i-int'(amt))*DATA_SIZE +: DATA_SIZE];
        else if (IS_SHIFT == 0)
          out_data[i*DATA_SIZE +: DATA_SIZE] =
            in_data[(i-int'(amt)+NUM_OUT)*DATA_SIZE +: DATA_SIZE];
      end else begin
        if (i + int'(amt) < NUM_OUT)
          out_data[i*DATA_SIZE +: DATA_SIZE] =
            in_data[(i+int'(amt))*DATA_SIZE +: DATA_SIZE];
        else if (IS_SHIFT == 0)
          out_data[i*DATA_SIZE +: DATA_SIZE] =
            in_data[(i+int'(amt)-NUM_OUT)*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

endmodule

// File: rtl/trace_line_packer.sv
// Packs variable-count trace beats into dense output lines.
// Optional idle auto-flush: define TRACE_PACK_TIMEOUT_EN.
module trace_line_packer
  import trace_pack_pkg::*;
#(
  parameter int NUM_IN    = 6,
  parameter int NUM_OUT   = 8,
  parameter int DATA_SIZE = 10,
  parameter int TMO_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic [cnt_w(NUM_IN)-1:0]     in_count,
  input  logic [NUM_IN*DATA_SIZE-1:0]  in_data,
  output logic                         in_ready,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic                         out_valid,
  output logic [cnt_w(NUM_OUT)-1:0]    out_count,
  output logic [NUM_OUT*DATA_SIZE-1:0] out_data,
  input  logic                         out_ready
`ifdef TRACE_PACK_TIMEOUT_EN
  ,
  input  logic [TMO_W-1:0]             tmo_limit
`endif
);

  localparam int ICW = cnt_w(NUM_IN);
  localparam int OCW = cnt_w(NUM_OUT);
  localparam int AW  = $clog2(NUM_OUT);
  localparam int WAW = $clog2(2*NUM_OUT);
  localparam int LW  = NUM_OUT*DATA_SIZE;

  if (NUM_IN < 1 || NUM_IN > NUM_OUT || TMO_W < 1 ||
      (NUM_OUT & (NUM_OUT-1)) != 0) begin : g_bad_cfg
    $error("trace_line_packer: bad parameters");
  end

  pack_state_e     state_q, state_d;
  logic [LW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   acc_cnt_q, acc_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [OCW-1:0]  out_count_q, out_count_d;
  logic [LW-1:0]   out_data_q, out_data_d;
  logic            flush_done_q, flush_done_d;
  logic            arm_q, arm_d;

  logic [2*LW-1:0] win_in, win_out;
  logic [LW-1:0]   merged, spill;
  logic [WAW-1:0]  total;
  logic            out_free, accept, flush_pend;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == RUN) && out_free;
  assign accept   = in_valid && in_ready;
  assign total    = WAW'(acc_cnt_q) + WAW'(in_count);

  // Drop entries beyond in_count so garbage never merges
  always_comb begin
    win_in = '0;
    for (int j = 0; j < NUM_IN; j++)
      if (j < int'(in_count))
        win_in[j*DATA_SIZE +: DATA_SIZE] = in_data[j*DATA_SIZE +: DATA_SIZE];
  end

  generic_rotate #(
    .NUM_OUT   (2*NUM_OUT),
    .DATA_SIZE (DATA_SIZE),
    .ROT_LEFT  (1),
    .IS_SHIFT  (1),
    .AMT_W     (WAW)
  ) u_rot (
    .in_data  (win_in),
    .amt      (WAW'(acc_cnt_q)),
    .out_data (win_out)
  );

  assign merged = acc_q | win_out[LW-1:0];
  assign spill  = win_out[2*LW-1:LW];

`ifdef TRACE_PACK_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;

  assign tmo_hit = (tmo_limit != '0) && (tmo_q == tmo_limit);

  // Count idle RUN cycles while a partial line sits in acc
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != RUN || accept) tmo_d = '0;
    else if (acc_cnt_q != '0)     tmo_d = tmo_q + 1'b1;
  end

  // Idle timer register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end

  assign flush_pend = flush_req || tmo_hit;
`else
  assign flush_pend = flush_req;
`endif

  // Next-state: merge beats, emit lines, run the flush FSM
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    out_valid_d  = out_valid_q;
    out_count_d  = out_count_q;
    out_data_d   = out_data_q;
    flush_done_d = 1'b0;
    arm_d        = arm_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          if (total >= WAW'(NUM_OUT)) begin
            out_valid_d = 1'b1;
            out_count_d = OCW'(NUM_OUT);
            out_data_d  = merged;
            acc_d       = spill;
            acc_cnt_d   = AW'(total - WAW'(NUM_OUT));
          end else begin
            acc_d     = merged;
            acc_cnt_d = AW'(total);
          end
        end else if (flush_pend && (arm_q || acc_cnt_q != '0)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (acc_cnt_q != '0) begin
          if (out_free) begin
            out_valid_d = 1'b1;
            out_count_d = OCW'(acc_cnt_q);
            out_data_d  = acc_q;
            acc_d       = '0;
            acc_cnt_d   = '0;
          end
        end else if (out_free) begin
          flush_done_d = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // A held request is served once until it drops
    if (flush_done_d)     arm_d = 1'b0;
    else if (!flush_pend) arm_d = 1'b1;
  end

  // All packer state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_count_q  <= '0;
      out_data_q   <= '0;
      flush_done_q <= 1'b0;
      arm_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      out_valid_q  <= out_valid_d;
      out_count_q  <= out_count_d;
      out_data_q   <= out_data_d;
      flush_done_q <= flush_done_d;
      arm_q        <= arm_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_count  = out_count_q;
  assign out_data   = out_data_q;
  assign flush_done = flush_done_q;

  a_in_count: assert property (@(posedge clk) disable iff (!reset_n)
    in_valid |-> (in_count <= ICW'(NUM_IN)));

endmodule
